button_event_gen: RTL and testbench

//   Consumes one debounced button level and emits one-cycle game-control events:

---
 rtl/button_event_gen.sv | 145 ++++++++++++++
 tb/tb_button_event_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: turns one debounced button level into one-cycle press,
// release, long-hold and auto-repeat events plus pressed/held levels.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ARM     | after reset; wait for the key to be seen released first
// IDLE    | key released, waiting for a press
// PRESSED | key down, hold timer running
// HELD    | key down past the hold time, repeat timer running
module button_event_gen #(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned HOLD_TIME   = 25_000_000,
  parameter int unsigned REPEAT_TIME = 5_000_000,
  parameter bit          REPEAT_EN   = 1'b1,
  parameter int unsigned CNT_W       = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_stable,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse,
  output logic pressed,
  output logic held
);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    HELD    = 2'd3
  } state_t;

  // Timers count down from period-1 and fire on terminal count zero.
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_LD = CNT_W'(REPEAT_TIME - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             btn_vld_q, btn_vld_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             hold_q, hold_d;
  logic             repeat_q, repeat_d;
  logic             pressed_q, pressed_d;
  logic             held_q, held_d;

  // State, timer, input sample and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARM;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      btn_vld_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      repeat_q  <= 1'b0;
      pressed_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      btn_vld_q <= btn_vld_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      repeat_q  <= repeat_d;
      pressed_q <= pressed_d;
      held_q    <= held_d;
    end
  end

  // Next-state, timer and event decode; release takes priority over timers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_d     = ACTIVE_LOW ? ~btn_stable : btn_stable;
    // btn_q holds its reset value on the first edge after reset, so ARM
    // must not trust it until it has been loaded from the real input once.
    btn_vld_d = 1'b1;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      ARM: begin
        if (btn_vld_q && !btn_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (btn_q) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d   = HOLD_LD;
        end
      end
      PRESSED: begin
        if (!btn_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == '0) begin
          state_d = HELD;
          hold_d  = 1'b1;
          cnt_d   = REPEAT_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HELD: begin
        if (!btn_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == '0) begin
          repeat_d = REPEAT_EN;
          cnt_d    = REPEAT_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ARM;
        cnt_d   = '0;
      end
    endcase

    pressed_d = (state_d == PRESSED) || (state_d == HELD);
    held_d    = (state_d == HELD);
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign hold_pulse    = hold_q;
  assign repeat_pulse  = repeat_q;
  assign pressed       = pressed_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen: stimulus pushes the expected pulse
// events, monitors pop and compare whenever a DUT pulse output is high.
module tb_button_event_gen;

  localparam logic [3:0] EV_PRESS   = 4'b0001;
  localparam logic [3:0] EV_RELEASE = 4'b0010;
  localparam logic [3:0] EV_HOLD    = 4'b0100;
  localparam logic [3:0] EV_REPEAT  = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btn, btn6;
  logic press0, rel0, hold0, rep0, pressed0, held0;
  logic press6, rel6, hold6, rep6, pressed6, held6;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int c;
  ev_t q0[$];
  ev_t q6[$];

  button_event_gen #(
    .ACTIVE_LOW(1'b1), .HOLD_TIME(8), .REPEAT_TIME(4), .REPEAT_EN(1'b1), .CNT_W(4)
  ) u0 (
    .clk(clk), .rst(rst), .btn_stable(btn),
    .press_pulse(press0), .release_pulse(rel0), .hold_pulse(hold0),
    .repeat_pulse(rep0), .pressed(pressed0), .held(held0)
  );

  button_event_gen #(
    .ACTIVE_LOW(1'b0), .HOLD_TIME(8), .REPEAT_TIME(4), .REPEAT_EN(1'b0), .CNT_W(4)
  ) u6 (
    .clk(clk), .rst(rst), .btn_stable(btn6),
    .press_pulse(press6), .release_pulse(rel6), .hold_pulse(hold6),
    .repeat_pulse(rep6), .pressed(pressed6), .held(held6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int id, input int at, input logic [3:0] code);
    ev_t e;
    e.cyc  = at;
    e.code = code;
    if (id == 0) q0.push_back(e);
    else q6.push_back(e);
  endtask

  task automatic check_pop(input int id, input logic [3:0] code, input logic p, input logic h);
    ev_t e;
    logic exp_p, exp_h;
    n_tests++;
    if ((id == 0 && q0.size() == 0) || (id != 0 && q6.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_pulse dut%0d: code %b at cycle %0d, required no pulse", id, code, cyc);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else e = q6.pop_front();
    exp_p = (e.code != EV_RELEASE);
    exp_h = (e.code == EV_HOLD) || (e.code == EV_REPEAT);
    if (code !== e.code || cyc != e.cyc || p !== exp_p || h !== exp_h) begin
      n_fail++;
      $display("FAIL pulse_event dut%0d: got code %b cyc %0d pressed %b held %b, required code %b cyc %0d pressed %b held %b",
               id, code, cyc, p, h, e.code, e.cyc, exp_p, exp_h);
    end
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor for the active-low, repeat-enabled instance.
  always @(negedge clk) begin
    if ({rep0, hold0, rel0, press0} != 4'b0000)
      check_pop(0, {rep0, hold0, rel0, press0}, pressed0, held0);
  end

  // Monitor for the active-high, repeat-disabled instance.
  always @(negedge clk) begin
    if ({rep6, hold6, rel6, press6} != 4'b0000)
      check_pop(6, {rep6, hold6, rel6, press6}, pressed6, held6);
  end

  initial begin
    rst  = 1'b0;
    btn  = 1'b0;
    btn6 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {press0, rel0, hold0, rep0, pressed0, held0}, 6'b0);
    rst = 1'b1;

    // Key held down through reset: no phantom press.
    repeat (20) @(negedge clk);
    chk("arm_held_through_reset", {press0, rel0, hold0, rep0, pressed0, held0}, 6'b0);
    btn = 1'b1;
    repeat (5) @(negedge clk);
    chk("arm_after_release", {press0, rel0, hold0, rep0, pressed0, held0}, 6'b0);
    c = cyc; btn = 1'b0; push(0, c + 2, EV_PRESS);
    repeat (3) @(negedge clk);
    btn = 1'b1; push(0, c + 5, EV_RELEASE);
    repeat (4) @(negedge clk);

    // One-cycle press.
    c = cyc; btn = 1'b0; push(0, c + 2, EV_PRESS);
    @(negedge clk);
    btn = 1'b1; push(0, c + 3, EV_RELEASE);
    repeat (4) @(negedge clk);

    // Short press of 5 cycles.
    c = cyc; btn = 1'b0; push(0, c + 2, EV_PRESS); push(0, c + 7, EV_RELEASE);
    for (int k = 0; k < 5; k++) begin
      wait_to(c + 2 + k);
      if (k == 3) btn = 1'b1;
      chk("short_pressed_level", {4'b0, pressed0, held0}, 6'b000010);
    end
    wait_to(c + 7);
    chk("short_after_release", {4'b0, pressed0, held0}, 6'b000000);
    repeat (3) @(negedge clk);

    // Long hold of 21 cycles with repeats.
    c = cyc; btn = 1'b0;
    push(0, c + 2, EV_PRESS);   push(0, c + 10, EV_HOLD);
    push(0, c + 14, EV_REPEAT); push(0, c + 18, EV_REPEAT);
    push(0, c + 22, EV_REPEAT); push(0, c + 23, EV_RELEASE);
    wait_to(c + 9);
    chk("hold_before_threshold", {4'b0, pressed0, held0}, 6'b000010);
    wait_to(c + 10);
    chk("hold_at_threshold", {4'b0, pressed0, held0}, 6'b000011);
    wait_to(c + 21);
    btn = 1'b1;
    wait_to(c + 22);
    chk("held_last_repeat", {4'b0, pressed0, held0}, 6'b000011);
    wait_to(c + 23);
    chk("held_after_release", {4'b0, pressed0, held0}, 6'b000000);
    repeat (3) @(negedge clk);

    // Release coincides with hold threshold: release wins.
    c = cyc; btn = 1'b0; push(0, c + 2, EV_PRESS);
    wait_to(c + 8);
    btn = 1'b1; push(0, c + 10, EV_RELEASE);
    wait_to(c + 11);
    chk("tie_release_wins", {4'b0, pressed0, held0}, 6'b000000);
    repeat (12) @(negedge clk);

    // Async reset while HELD, key still down.
    c = cyc; btn = 1'b0; push(0, c + 2, EV_PRESS); push(0, c + 10, EV_HOLD);
    wait_to(c + 12);
    chk("pre_reset_held", {4'b0, pressed0, held0}, 6'b000011);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {press0, rel0, hold0, rep0, pressed0, held0}, 6'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_press_after_reset", {press0, rel0, hold0, rep0, pressed0, held0}, 6'b0);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    c = cyc; btn = 1'b0; push(0, c + 2, EV_PRESS);
    repeat (2) @(negedge clk);
    btn = 1'b1; push(0, c + 4, EV_RELEASE);
    repeat (4) @(negedge clk);

    // Active-high, repeat disabled: hold 20 cycles.
    c = cyc; btn6 = 1'b1; push(6, c + 2, EV_PRESS); push(6, c + 10, EV_HOLD);
    wait_to(c + 19);
    chk("noreps_held_level", {4'b0, pressed6, held6}, 6'b000011);
    wait_to(c + 20);
    btn6 = 1'b0; push(6, c + 22, EV_RELEASE);
    wait_to(c + 23);
    chk("noreps_after_release", {4'b0, pressed6, held6}, 6'b000000);
    repeat (5) @(negedge clk);

    n_tests++;
    if (q0.size() != 0 || q6.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: %0d and %0d events still pending, required 0", q0.size(), q6.size());
      while (q0.size() != 0) begin
        $display("  pending dut0 code %b cyc %0d", q0[0].code, q0[0].cyc);
        void'(q0.pop_front());
      end
      while (q6.size() != 0) begin
        $display("  pending dut6 code %b cyc %0d", q6[0].code, q6[0].cyc);
        void'(q6.pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
